// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for FPGA configuration loaders: loader state encoding,
// tile sizing helper and the legal K/N limits used by every loader.
package fpga_cfg_pkg;

    typedef enum logic [1:0] {
        UNCONF,
        LOAD,
        ACTIVE
    } cfg_state_e;

    localparam int K_MIN = 2;
    localparam int K_MAX = 6;
    localparam int N_MIN = 1;
    localparam int N_MAX = 16;

    // One bit per LUT entry plus the output-mode bit.
    function automatic int bits_per_tile(input int k);
        return (1 << k) + 1;
    endfunction

endpackage

// File: rtl/lut_tile.sv
// One K-input logic tile: 2^K-entry LUT, mode bit, optional output flop and
// a configuration write port that also returns the cell's previous content.
module lut_tile
    import fpga_cfg_pkg::*;
#(
    parameter int K = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         we,
    input  logic [K:0]   addr,
    input  logic         din,
    output logic         old_bit,
    input  logic         clr,
    input  logic         active,
    input  logic [K-1:0] in,
    output logic         out
);
    localparam int ENTRIES = 1 << K;

    logic [ENTRIES-1:0] lut_q, lut_d;
    logic               mode_q, mode_d;
    logic               q_q, q_d;
    logic               lut_val;

    // addr[K] is set only for the mode-bit slot, which follows the last LUT entry.
    always_comb begin
        lut_d  = lut_q;
        mode_d = mode_q;
        if (we) begin
            if (addr[K]) begin
                mode_d = din;
            end else begin
                lut_d[addr[K-1:0]] = din;
            end
        end
    end

    assign lut_val = lut_q[in];
    assign old_bit = addr[K] ? mode_q : lut_q[addr[K-1:0]];
    assign q_d     = clr ? 1'b0 : lut_val;
    assign out     = active && (mode_q ? q_q : lut_val);

    // NOTE: the LUT array is reset on purpose -- an unconfigured tile must read back as all zeros.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lut_q  <= '0;
            mode_q <= 1'b0;
            q_q    <= 1'b0;
        end else begin
            lut_q  <= lut_d;
            mode_q <= mode_d;
            q_q    <= q_d;
        end
    end

endmodule

// File: rtl/lut_cluster_cfg.sv
// Cluster of N K-input LUT tiles with a bit-serial configuration loader.
// Optional readback of the previous bitstream on cfg_dout under CFG_READBACK_EN.
module lut_cluster_cfg
    import fpga_cfg_pkg::*;
#(
    parameter int K = 5,
    parameter int N = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [K-1:0] in,
    output logic [N-1:0] out,
    input  logic         cfg_start,
    input  logic         cfg_valid,
    input  logic         cfg_data,
    output logic         cfg_ready,
    output logic         cfg_done
`ifdef CFG_READBACK_EN
    ,
    output logic         cfg_dout
`endif
);
    localparam int BPT   = bits_per_tile(K);
    localparam int TOTAL = N * BPT;
    localparam int BW    = $clog2(TOTAL);
    localparam int AW    = K + 1;

    cfg_state_e    state_q, state_d;
    logic [BW-1:0] b_q, b_d;
    logic [BW-1:0] tile_idx;
    logic [AW-1:0] offset;
    logic          accept, last_bit, active, q_clr;
    logic [N-1:0]  we, old_bits;

    assign cfg_ready = (state_q == LOAD) && !cfg_start;
    assign accept    = cfg_valid && cfg_ready;
    assign last_bit  = (b_q == BW'(TOTAL - 1));
    assign tile_idx  = b_q / BW'(BPT);
    assign offset    = AW'(b_q % BW'(BPT));
    assign active    = (state_q == ACTIVE);
    assign cfg_done  = active;
    // Flops run only while staying in ACTIVE, so they are already clear on LOAD entry.
    assign q_clr     = !active || (state_d != ACTIVE);

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        unique case (state_q)
            UNCONF: begin
                if (cfg_start) begin
                    state_d = LOAD;
                    b_d     = '0;
                end
            end
            LOAD: begin
                if (cfg_start) begin
                    b_d = '0;
                end else if (accept) begin
                    if (last_bit) begin
                        state_d = ACTIVE;
                        b_d     = '0;
                    end else begin
                        b_d = b_q + BW'(1);
                    end
                end
            end
            ACTIVE: begin
                if (cfg_start) begin
                    state_d = LOAD;
                    b_d     = '0;
                end
            end
            default: state_d = UNCONF;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= UNCONF;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
        end
    end

    for (genvar t = 0; t < N; t++) begin : g_tile
        assign we[t] = accept && (tile_idx == BW'(t));

        lut_tile #(.K(K)) u_tile (
            .clock   (clock),
            .reset   (reset),
            .we      (we[t]),
            .addr    (offset),
            .din     (cfg_data),
            .old_bit (old_bits[t]),
            .clr     (q_clr),
            .active  (active),
            .in      (in),
            .out     (out[t])
        );
    end

`ifdef CFG_READBACK_EN
    logic cfg_dout_q, cfg_dout_d;

    always_comb begin
        cfg_dout_d = cfg_dout_q;
        for (int t = 0; t < N; t++) begin
            if (we[t]) cfg_dout_d = old_bits[t];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cfg_dout_q <= 1'b0;
        end else begin
            cfg_dout_q <= cfg_dout_d;
        end
    end

    assign cfg_dout = cfg_dout_q;
`else
    logic unused_old_bits;
    assign unused_old_bits = ^old_bits;
`endif

endmodule

// File: tb/tb_lut_cluster_cfg.sv
// Self-checking bench for lut_cluster_cfg (K=2, N=2) against a behavioural
// model of the loader, LUT contents and output flops.
module tb_lut_cluster_cfg;
    localparam int K     = 2;
    localparam int N     = 2;
    localparam int E     = 4;
    localparam int BPT   = 5;
    localparam int TOTAL = 10;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [K-1:0]     in = '0;
    logic [N-1:0]     out;
    logic             cfg_start = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             cfg_data = 1'b0;
    logic             cfg_ready;
    logic             cfg_done;
`ifdef CFG_READBACK_EN
    logic             cfg_dout;
    bit               rb_q[$];
`endif

    int checks = 0;
    int failures = 0;
    int dut_accepts = 0;

    typedef enum {M_UNCONF, M_LOAD, M_ACTIVE} mstate_e;
    mstate_e m_st;
    int      m_b;
    bit      m_lut[N][E];
    bit      m_mode[N];
    bit      m_q[N];
    bit      m_dout;

    lut_cluster_cfg #(.K(K), .N(N)) dut (
        .clock     (clock),
        .reset     (reset),
        .in        (in),
        .out       (out),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done)
`ifdef CFG_READBACK_EN
        ,
        .cfg_dout  (cfg_dout)
`endif
    );

    always #5 clock = ~clock;

    function automatic void model_clear();
        m_st = M_UNCONF;
        m_b = 0;
        m_dout = 0;
        for (int i = 0; i < N; i++) begin
            m_mode[i] = 0;
            m_q[i] = 0;
            for (int e = 0; e < E; e++) m_lut[i][e] = 0;
        end
    endfunction

    function automatic logic [N-1:0] exp_out();
        logic [N-1:0] r = '0;
        for (int i = 0; i < N; i++)
            if (m_st == M_ACTIVE) r[i] = m_mode[i] ? m_q[i] : m_lut[i][in];
        return r;
    endfunction

    function automatic logic exp_ready();
        return (m_st == M_LOAD) && !cfg_start;
    endfunction

    function automatic logic exp_done();
        return m_st == M_ACTIVE;
    endfunction

    // Advance one clock: called at a falling edge with inputs already driven.
    task automatic tick();
        bit acc;
        bit lv[N];
        int t, o;
        mstate_e nst;
        #1;
        if (cfg_ready && cfg_valid) dut_accepts++;
        acc = cfg_valid && (m_st == M_LOAD) && !cfg_start;
        nst = m_st;
        for (int i = 0; i < N; i++) lv[i] = m_lut[i][in];
        if (acc) begin
            t = m_b / BPT;
            o = m_b % BPT;
            m_dout = (o < E) ? m_lut[t][o] : m_mode[t];
            if (o < E) m_lut[t][o] = cfg_data;
            else       m_mode[t] = cfg_data;
            m_b++;
            if (m_b == TOTAL) begin
                nst = M_ACTIVE;
                m_b = 0;
            end
        end
        if (cfg_start) begin
            nst = M_LOAD;
            m_b = 0;
        end
        for (int i = 0; i < N; i++) m_q[i] = (m_st == M_ACTIVE && nst == M_ACTIVE) ? lv[i] : 1'b0;
        m_st = nst;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        model_clear();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // gap: 0 = valid every cycle, 1 = every other cycle, 2 = random.
    task automatic send_stream(input logic [TOTAL-1:0] s, input int gap, input int stop_after);
        int sent = 0;
        int cyc = 0;
        bit acc;
        cfg_start = 1'b1;
        cfg_valid = 1'b0;
        tick();
        cfg_start = 1'b0;
        while (sent < stop_after && cyc < 200) begin
            cfg_valid = (gap == 0) ? 1'b1 : (gap == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            cfg_data = s[sent];
            acc = cfg_valid && (m_st == M_LOAD);
            tick();
`ifdef CFG_READBACK_EN
            if (acc) rb_q.push_back(cfg_dout);
`endif
            if (acc) sent++;
            cyc++;
        end
        cfg_valid = 1'b0;
        if (cyc >= 200) begin
            checks++;
            failures++;
            $display("FAIL load_timeout sent=%0d required=%0d", sent, stop_after);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({out, cfg_ready, cfg_done} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_state out=%b ready=%b done=%b required 00/0/0", out, cfg_ready, cfg_done);
        end
`ifdef CFG_READBACK_EN
        checks++;
        if (cfg_dout !== 1'b0) begin
            failures++;
            $display("FAIL reset_dout got=%b required=0", cfg_dout);
        end
`endif
        for (int v = 0; v < E; v++) begin
            in = K'(v);
            #1;
            checks++;
            if (out !== 2'b00) begin
                failures++;
                $display("FAIL unconf_out in=%0d got=%b required=00", v, out);
            end
            tick();
        end
    endtask

    task automatic test_basic_load(input int gap, input string name);
        dut_accepts = 0;
        send_stream(10'b1100000110, gap, TOTAL);
        checks++;
        if (dut_accepts !== TOTAL || cfg_done !== 1'b1) begin
            failures++;
            $display("FAIL %s_load accepts=%0d done=%b required 10/1", name, dut_accepts, cfg_done);
        end
        in = 2'b01;
        #1;
        checks++;
        if (out[0] !== 1'b1) begin
            failures++;
            $display("FAIL %s_xor_comb got=%b required=1", name, out[0]);
        end
        tick();
        in = 2'b11;
        #1;
        checks++;
        if (out !== 2'b00) begin
            failures++;
            $display("FAIL %s_and_before_edge got=%b required=00", name, out);
        end
        tick();
        checks++;
        if (out !== 2'b10) begin
            failures++;
            $display("FAIL %s_and_registered got=%b required=10", name, out);
        end
        for (int c = 0; c < 12; c++) begin
            in = K'($urandom_range(0, E - 1));
            #1;
            checks++;
            if ({out, cfg_ready, cfg_done} !== {exp_out(), exp_ready(), exp_done()}) begin
                failures++;
                $display("FAIL %s_active in=%b out=%b/%b/%b required %b/%b/%b", name, in, out,
                         cfg_ready, cfg_done, exp_out(), exp_ready(), exp_done());
            end
            tick();
        end
    endtask

    task automatic test_restart();
        send_stream(10'($urandom), 0, 6);
        checks++;
        if (cfg_done !== 1'b0 || cfg_ready !== 1'b1 || out !== 2'b00) begin
            failures++;
            $display("FAIL restart_partial done=%b ready=%b out=%b required 0/1/00", cfg_done, cfg_ready, out);
        end
        send_stream(10'h3FF, 0, TOTAL);
        in = 2'b00;
        tick();
        checks++;
        if (out !== 2'b11) begin
            failures++;
            $display("FAIL restart_all_ones got=%b required=11", out);
        end
    endtask

    task automatic test_restart_on_last_bit();
        send_stream(10'($urandom), 0, TOTAL - 1);
        cfg_valid = 1'b1;
        cfg_data = 1'b1;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        #1;
        checks++;
        if (cfg_done !== 1'b0 || cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL restart_last_bit done=%b ready=%b required 0/1", cfg_done, cfg_ready);
        end
        send_stream(10'($urandom), 2, TOTAL);
        checks++;
        if (cfg_done !== 1'b1) begin
            failures++;
            $display("FAIL restart_last_bit_reload done=%b required=1", cfg_done);
        end
    endtask

    task automatic test_reset_midload();
        send_stream(10'h3FF, 0, 4);
        do_reset();
        #1;
        checks++;
        if ({out, cfg_ready, cfg_done} !== 4'b0000) begin
            failures++;
            $display("FAIL midload_reset out=%b ready=%b done=%b required 00/0/0", out, cfg_ready, cfg_done);
        end
        send_stream(10'($urandom), 2, TOTAL);
        for (int c = 0; c < 10; c++) begin
            in = K'($urandom_range(0, E - 1));
            #1;
            checks++;
            if ({out, cfg_done} !== {exp_out(), exp_done()}) begin
                failures++;
                $display("FAIL midload_reload in=%b out=%b done=%b required %b/%b", in, out, cfg_done,
                         exp_out(), exp_done());
            end
            tick();
        end
    endtask

    task automatic test_random_loads();
        for (int r = 0; r < 4; r++) begin
            send_stream(10'($urandom), 2, TOTAL);
            for (int c = 0; c < 10; c++) begin
                in = K'($urandom_range(0, E - 1));
                cfg_start = (c == 9) && (r[0] == 1'b1);
                #1;
                checks++;
                if ({out, cfg_ready, cfg_done} !== {exp_out(), exp_ready(), exp_done()}) begin
                    failures++;
                    $display("FAIL random_load r=%0d in=%b out=%b/%b/%b required %b/%b/%b", r, in, out,
                             cfg_ready, cfg_done, exp_out(), exp_ready(), exp_done());
                end
`ifdef CFG_READBACK_EN
                checks++;
                if (cfg_dout !== m_dout) begin
                    failures++;
                    $display("FAIL random_dout got=%b required=%b", cfg_dout, m_dout);
                end
`endif
                tick();
            end
            cfg_start = 1'b0;
        end
    endtask

`ifdef CFG_READBACK_EN
    task automatic test_readback();
        logic [TOTAL-1:0] a, b;
        a = 10'($urandom);
        b = 10'($urandom);
        send_stream(a, 0, TOTAL);
        rb_q.delete();
        send_stream(b, 2, TOTAL);
        checks++;
        if (rb_q.size() != TOTAL) begin
            failures++;
            $display("FAIL readback_count got=%0d required=%0d", rb_q.size(), TOTAL);
        end else begin
            for (int i = 0; i < TOTAL; i++) begin
                checks++;
                if (rb_q[i] !== a[i]) begin
                    failures++;
                    $display("FAIL readback_bit%0d got=%b required=%b", i, rb_q[i], a[i]);
                end
            end
        end
    endtask
`endif

    initial begin
        model_clear();
        test_reset();
        test_basic_load(0, "basic");
        test_basic_load(1, "gapped");
        test_restart();
        test_restart_on_last_bit();
        test_reset_midload();
        test_random_loads();
`ifdef CFG_READBACK_EN
        test_readback();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
